// File: rtl/sqrt_job_sequencer_if.sv
// Handshake and datapath bundle between the job source, the sequencer and the sqrt core.
// The sequencer connects through the slave modport; the job source/core side uses master.
interface sqrt_job_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] op_data;
    logic              start;
    logic              done;
    logic [RES_W-1:0]  res_data;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              out_err;
    logic              busy;

    modport slave (
        input  in_valid, in_data, done, res_data, out_ready,
        output in_ready, op_data, start, out_valid, out_data, out_err, busy
    );

    modport master (
        output in_valid, in_data, done, res_data, out_ready,
        input  in_ready, op_data, start, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/sqrt_job_sequencer.sv
// Single-job front-end for the sqrt core: latch operand, pulse start, wait for done
// (with watchdog), then hold the result until the consumer takes it.
module sqrt_job_sequencer #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_job_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic [DATA_W-1:0]  op_data_q, op_data_d;
    logic [RES_W-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            op_data_q  <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            op_data_q  <= op_data_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        op_data_d  = op_data_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_data_d = bus.in_data;
                    start_d   = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // A done seen here belongs to an abandoned job, so it is not looked at.
                start_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so a result on the last watchdog cycle still counts.
                if (bus.done) begin
                    out_data_d = bus.res_data;
                    out_err_d  = 1'b0;
                    state_d    = ST_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.start     = start_q;
    assign bus.op_data   = op_data_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Bench for sqrt_job_sequencer: table of directed jobs, randomized jobs against a
// transaction-level timing model, and hand sequences for reset and back-to-back jobs.
module tb_sqrt_job_sequencer;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sqrt_job_sequencer_if #(.DATA_W(16), .RES_W(16)) sif ();

    sqrt_job_sequencer #(.DATA_W(16), .RES_W(16), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int op;
        int d;
        int hold;
        int exp_data;
        int exp_err;
        int exp_lat;
    } vec_t;

    vec_t vecs[8];

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"},     int'(sif.start), 0);
        chk({tag, "_out_valid"}, int'(sif.out_valid), 0);
        chk({tag, "_out_data"},  int'(sif.out_data), 0);
        chk({tag, "_out_err"},   int'(sif.out_err), 0);
        chk({tag, "_op_data"},   int'(sif.op_data), 0);
        chk({tag, "_busy"},      int'(sif.busy), 0);
        chk({tag, "_in_ready"},  int'(sif.in_ready), 1);
    endtask

    // d >= 0: done pulse d cycles after the start cycle (d=0 lands on the start cycle); d < 0: never.
    task automatic run_job(input int op, input int d, input int hold,
                           input int exp_data, input int exp_err, input int exp_lat);
        int lat;
        int res;
        res = isqrt(op);
        @(negedge clk);
        chk("in_ready_idle", int'(sif.in_ready), 1);
        sif.in_valid = 1'b1;
        sif.in_data  = 16'(op);
        @(negedge clk);
        sif.in_valid = 1'b0;
        chk("start_pulse", int'(sif.start), 1);
        chk("op_data", int'(sif.op_data), op);
        chk("in_ready_busy", int'(sif.in_ready), 0);
        if (d == 0) begin
            sif.done     = 1'b1;
            sif.res_data = 16'(res);
        end
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            sif.done = 1'b0;
            if (k == 1) chk("start_width", int'(sif.start), 0);
            if (sif.out_valid) begin
                lat = k;
                break;
            end
            sif.out_ready = 1'($urandom_range(0, 1));
            if (k == d) begin
                sif.done     = 1'b1;
                sif.res_data = 16'(res);
            end else begin
                sif.res_data = 16'($urandom_range(0, 65535));
            end
        end
        sif.out_ready = 1'b0;
        chk("latency", lat, exp_lat);
        if (lat < 0) return;
        chk("out_data", int'(sif.out_data), exp_data);
        chk("out_err", int'(sif.out_err), exp_err);
        for (int h = 0; h < hold; h++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 16'(op ^ 16'h5a5a);
            @(negedge clk);
            chk("hold_valid", int'(sif.out_valid), 1);
            chk("hold_data", int'(sif.out_data), exp_data);
            chk("hold_err", int'(sif.out_err), exp_err);
            chk("hold_in_ready", int'(sif.in_ready), 0);
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
        chk("post_valid", int'(sif.out_valid), 0);
        chk("post_busy", int'(sif.busy), 0);
        chk("post_in_ready", int'(sif.in_ready), 1);
        chk("op_not_consumed", int'(sif.op_data), op);
    endtask

    initial begin
        int op, d, r, ed, ee, nres, starts, wide, done_at, rsp;
        int res_got[2];
        logic start_prev;

        vecs[0] = '{op: 144,   d: 10, hold: 0, exp_data: 12,  exp_err: 0, exp_lat: 11};
        vecs[1] = '{op: 144,   d: 10, hold: 5, exp_data: 12,  exp_err: 0, exp_lat: 11};
        vecs[2] = '{op: 1000,  d: -1, hold: 0, exp_data: 0,   exp_err: 1, exp_lat: 65};
        vecs[3] = '{op: 49,    d: 64, hold: 0, exp_data: 7,   exp_err: 0, exp_lat: 65};
        vecs[4] = '{op: 81,    d: 0,  hold: 0, exp_data: 0,   exp_err: 1, exp_lat: 65};
        vecs[5] = '{op: 81,    d: 65, hold: 0, exp_data: 0,   exp_err: 1, exp_lat: 65};
        vecs[6] = '{op: 0,     d: 1,  hold: 2, exp_data: 0,   exp_err: 0, exp_lat: 2};
        vecs[7] = '{op: 65535, d: 1,  hold: 0, exp_data: 255, exp_err: 0, exp_lat: 2};

        rst_n         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.done      = 1'b0;
        sif.res_data  = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i])
            run_job(vecs[i].op, vecs[i].d, vecs[i].hold,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);

        // Random jobs: result arrives one cycle after any done inside the watchdog window.
        for (int j = 0; j < 12; j++) begin
            op = int'($urandom_range(0, 65535));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      d = -1;
            else if (r == 1) d = int'($urandom_range(60, 70));
            else             d = int'($urandom_range(0, 20));
            if (d >= 1 && d <= TO) begin
                ed = isqrt(op); ee = 0;
                run_job(op, d, int'($urandom_range(0, 3)), ed, ee, d + 1);
            end else begin
                ed = 0; ee = 1;
                run_job(op, d, int'($urandom_range(0, 3)), ed, ee, TO + 1);
            end
        end

        // Reset while waiting, then a stale done arriving in IDLE.
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = 16'd200;
        @(negedge clk);
        sif.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("midreset");
        sif.done     = 1'b1;
        sif.res_data = 16'd99;
        @(negedge clk);
        sif.done = 1'b0;
        chk_reset_outputs("late_done");
        @(negedge clk);
        chk_reset_outputs("late_done2");

        // Back-to-back operands with in_valid held and the consumer always ready.
        nres = 0; starts = 0; wide = 0; done_at = -1; rsp = 0; start_prev = 1'b0;
        res_got[0] = -1; res_got[1] = -1;
        sif.in_valid  = 1'b1;
        sif.in_data   = 16'd25;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 200 && nres < 2; c++) begin
            @(negedge clk);
            sif.done = 1'b0;
            if (sif.start) begin
                if (start_prev) wide++;
                else begin
                    starts++;
                    done_at = c + 3;
                    rsp = isqrt(int'(sif.op_data));
                    sif.in_data = 16'd49;
                    if (starts >= 2) sif.in_valid = 1'b0;
                end
            end
            if (sif.out_valid) begin
                if (nres < 2) res_got[nres] = int'(sif.out_data);
                nres++;
            end
            if (c == done_at) begin
                sif.done     = 1'b1;
                sif.res_data = 16'(rsp);
            end
            start_prev = sif.start;
        end
        sif.done      = 1'b0;
        sif.in_valid  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sif.start) starts++;
        end
        sif.out_ready = 1'b0;
        chk("b2b_count", nres, 2);
        chk("b2b_res0", res_got[0], 5);
        chk("b2b_res1", res_got[1], 7);
        chk("b2b_starts", starts, 2);
        chk("b2b_wide_start", wide, 0);
        chk("b2b_idle", int'(sif.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
